// File: rtl/bavg_pkg.sv
// Shared types and defaults for the N-channel stochastic bitstream averager.
package bavg_pkg;

    typedef enum logic [1:0] {
        BAVG_RR    = 2'b00,
        BAVG_LFSR  = 2'b01,
        BAVG_EXACT = 2'b10,
        BAVG_RSVD  = 2'b11
    } mode_e;

    localparam logic [15:0] BAVG_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] BAVG_LFSR_SEED = 16'hACE1;

    // Select-index width; a 2-channel averager still needs one index bit.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with synchronous clear and step enable; state is the register itself.
module lfsr_galois #(
    parameter int unsigned     W    = 16,
    parameter logic [W-1:0]    TAPS = 16'hB400,
    parameter logic [W-1:0]    SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         step,
    output logic [W-1:0] state
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = SEED;
        end else if (step) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bitstream_averager.sv
// N-channel stochastic scaled adder: one output bit per enabled cycle whose density is the
// mean of the input densities, by round-robin, LFSR-random or exact accumulate selection.
module bitstream_averager
    import bavg_pkg::*;
#(
    parameter int unsigned          N_CH      = 4,
    parameter int unsigned          LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]    LFSR_TAPS = BAVG_LFSR_TAPS,
    parameter logic [LFSR_W-1:0]    LFSR_SEED = BAVG_LFSR_SEED,
    localparam int unsigned         IDXW      = idx_width(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [N_CH-1:0] x,
    output logic            y,
    output logic            y_valid,
    output logic [IDXW-1:0] sel_dbg
);

    localparam logic [IDXW:0]   NCH_W   = (IDXW + 1)'(N_CH);
    localparam logic [IDXW-1:0] SEL_MAX = IDXW'(N_CH - 1);

    logic [IDXW-1:0]   sel_q, sel_d;
    logic [IDXW-1:0]   acc_q, acc_d;
    logic              y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr_state;

    logic [IDXW:0]     pop;
    logic [IDXW:0]     acc_sum;
    logic [IDXW:0]     lfsr_r;
    logic [IDXW-1:0]   lfsr_idx;
    logic              unused_lfsr_hi;

    lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Only the low index bits choose a channel; the rest just feed the sequence.
    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:IDXW];

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + (IDXW + 1)'(x[i]);
        end
    end

    assign acc_sum = {1'b0, acc_q} + pop;

    // r < 2^IDXW <= 2*N_CH, so a single conditional subtract folds r into range.
    assign lfsr_r   = {1'b0, lfsr_state[IDXW-1:0]};
    assign lfsr_idx = (lfsr_r >= NCH_W) ? IDXW'(lfsr_r - NCH_W) : lfsr_state[IDXW-1:0];

    always_comb begin
        sel_d     = sel_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        lfsr_step = 1'b0;
        if (clr) begin
            sel_d = '0;
            acc_d = '0;
            y_d   = 1'b0;
        end else if (en) begin
            y_valid_d = 1'b1;
            unique case (mode_e'(mode))
                BAVG_RR: begin
                    y_d   = x[sel_q];
                    sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + IDXW'(1);
                end
                BAVG_LFSR: begin
                    y_d       = x[lfsr_idx];
                    lfsr_step = 1'b1;
                end
                BAVG_EXACT: begin
                    if (acc_sum >= NCH_W) begin
                        y_d   = 1'b1;
                        acc_d = IDXW'(acc_sum - NCH_W);
                    end else begin
                        y_d   = 1'b0;
                        acc_d = acc_sum[IDXW-1:0];
                    end
                end
                BAVG_RSVD: begin
                    y_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            acc_q     <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign sel_dbg = sel_q;

endmodule
